button_event_tx: RTL and testbench
==================================

BUTTON_EVENT_TX -- requirements
Module: button_event_tx

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of button inputs, legal range 1..8.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 270000: consecutive stable cycles needed to accept a level change, legal minimum 16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: event FIFO entries, power of two, legal range 2..256.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means a button reads 0 when pressed.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port btn, input, NUM_BTN bits: raw, asynchronous button levels.
REQ-008 SHALL have port tx_data, output, 8 bits: event byte to the UART transmitter.
REQ-009 SHALL have port tx_data_valid, output, 1 bit: tx_data holds a valid byte.
REQ-010 SHALL have port tx_data_ready, input, 1 bit: the transmitter accepts a byte.
REQ-011 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: number of occupied FIFO entries.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when an event was dropped.

Function
REQ-013 SHALL pass each btn bit through a 2-flop synchroniser, then normalise it so that 1 means pressed (invert when ACTIVE_LOW=1).
REQ-014 SHALL keep, per button, a debounce counter and a stable-state bit; the counter clears whenever the synchronised level equals the stable state.
REQ-015 SHALL, when the counter reaches DEBOUNCE_CYCLES, on that edge: toggle the stable state, clear the counter, and set that button's pending-event bit together with its polarity (press or release).
REQ-016 SHALL encode events as single bytes: a press of button i is ASCII "A"+i (8'h41+i); a release of button i is ASCII "a"+i (8'h61+i).
REQ-017 SHALL write at most one pending event per cycle into the FIFO, choosing the lowest-index pending button first; the write occurs on the edge after the pending bit is set, and that pending bit clears on the same edge.
REQ-018 SHALL, when the FIFO is full at write time, discard the selected event, clear its pending bit, and set overflow; FIFO contents are unaffected.
REQ-019 SHALL use a registered output stage: if the stage is empty, or is transferring in the same cycle, it loads the FIFO head on the next edge; tx_data_valid therefore rises exactly 1 cycle after an FIFO write into an empty FIFO with an empty stage.
REQ-020 SHALL treat a transfer as occurring only when tx_data_valid and tx_data_ready are both 1 on a rising edge; while valid is high and ready is low, tx_data SHALL remain stable.
REQ-021 SHALL deliver back-to-back bytes: when ready is held high and the FIFO is non-empty, a new byte is presented every cycle.
REQ-022 SHALL allow a simultaneous FIFO write and read, leaving fifo_level unchanged; a write to a full FIFO during a read of the same cycle SHALL succeed.
REQ-023 SHALL count fifo_level entries in the FIFO only, excluding the output stage; read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-024 SHALL, while rst=1 on an edge, set: tx_data=8'h00, tx_data_valid=0, fifo_level=0, overflow=0, FIFO pointers=0, all pending bits=0, debounce counters=0.
REQ-025 SHALL reset stable states and synchroniser flops to "released"; a button held through reset SHALL produce a press event after debounce.
REQ-026 SHALL, on a reset asserted mid-transfer or with a non-empty FIFO, discard all queued and pending events; no partial byte is presented afterwards.

Configuration
REQ-027 SHALL support macro BUTTON_EVT_DEBOUNCE_EN: when defined, debounce behaves as in REQ-014/015.
REQ-028 SHALL, when BUTTON_EVT_DEBOUNCE_EN is undefined, omit the counters and ignore DEBOUNCE_CYCLES; any change of the synchronised level updates the stable state and sets the pending bit on the same edge.

Verification
REQ-029 SHALL cover: NUM_BTN=4, DEBOUNCE_CYCLES=16, ready=1; press btn[2] cleanly -> a single 8'h43 appears; on release -> a single 8'h63 appears.
REQ-030 SHALL cover: bounce btn[0] with 5-cycle pulses for 100 cycles, then hold -> exactly one 8'h41 appears, with no spurious bytes.
REQ-031 SHALL cover: press btn[0], btn[1] and btn[3] with identical timing -> bytes 8'h41, 8'h42, 8'h44 appear in that order on consecutive FIFO writes.
REQ-032 SHALL cover: FIFO_DEPTH=4, ready=0, generate 6 events -> fifo_level=4, overflow=1, the output stage holds the first byte; after ready=1 exactly 5 bytes drain, in event order.
REQ-033 SHALL cover: assert rst for 1 cycle while fifo_level=3 -> the next cycle shows valid=0, level=0, overflow=0, and no further bytes appear.
REQ-034 SHALL cover: with the macro undefined, a 1-cycle glitch on btn[1] -> bytes 8'h42 then 8'h62 appear.

Source files
------------

// File: rtl/button_event_tx.sv
//------------------------------------------------------------------------------
// Module   : button_event_tx
// Purpose  : Synchronises and debounces NUM_BTN push buttons, turns every
//            accepted press/release into one ASCII byte ("A"+i / "a"+i),
//            queues the bytes in a FIFO and presents them to a UART
//            transmitter through a valid/ready registered output stage.
// Config   : BUTTON_EVT_DEBOUNCE_EN - when defined, a level change must be
//            stable for DEBOUNCE_CYCLES cycles before it is accepted; when
//            undefined, every synchronised level change is an event.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_event_tx #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int FIFO_DEPTH      = 16,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_BTN-1:0]            btn,
   output logic [7:0]                    tx_data,
   output logic                          tx_data_valid,
   input  logic                          tx_data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   // Raw level of a released button; the synchroniser resets to it so a
   // button held through reset is later seen as a fresh press.
   localparam logic [NUM_BTN-1:0] RELEASED_RAW = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}}
                                                                   : {NUM_BTN{1'b0}};

   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;
   logic [NUM_BTN-1:0] level;      // normalised: 1 = pressed
   logic [NUM_BTN-1:0] stable;     // accepted (debounced) state
   logic [NUM_BTN-1:0] toggle;     // stable state changes on this edge
   logic [NUM_BTN-1:0] pend;       // event waiting to be queued
   logic [NUM_BTN-1:0] pol;        // 1 = press, 0 = release
   logic [NUM_BTN-1:0] pend_clr;

   logic               sel_valid;
   logic [2:0]         sel_idx;
   logic               sel_pol;
   logic [7:0]         evt_byte;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               fifo_full;
   logic               fifo_wr;
   logic               fifo_rd;

   // Two-flop synchroniser for the asynchronous button inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= RELEASED_RAW;
         sync2 <= RELEASED_RAW;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

`ifdef BUTTON_EVT_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt [NUM_BTN];

   // A change is accepted on the edge that completes DEBOUNCE_CYCLES
   // consecutive differing cycles
   always_comb begin
      toggle = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         toggle[i] = (level[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
   end

   // Per-button debounce counters; any return to the stable level restarts them
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (level[i] == stable[i] || toggle[i]) cnt[i] <= '0;
            else                                    cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
`else
   logic unused_debounce;
   assign unused_debounce = (DEBOUNCE_CYCLES != 0);

   // Without debounce every synchronised change is accepted immediately
   always_comb begin
      toggle = level ^ stable;
   end
`endif

   // Accepted state, pending-event bits and their polarity; a new event
   // wins over the clear of the one being queued on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= '0;
         pend   <= '0;
         pol    <= '0;
      end else begin
         stable <= stable ^ toggle;
         pend   <= (pend & ~pend_clr) | toggle;
         pol    <= (pol & ~toggle) | (level & toggle);
      end
   end

   // Lowest-index pending button is queued first
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 3'd0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend[i]) begin
            sel_valid = 1'b1;
            sel_idx   = 3'(i);
         end
      end
   end

   assign sel_pol  = pol[sel_idx];
   assign evt_byte = sel_pol ? (8'h41 + {5'd0, sel_idx}) : (8'h61 + {5'd0, sel_idx});
   assign pend_clr = sel_valid ? (NUM_BTN'(1) << sel_idx) : '0;

   // Output stage refills whenever it is empty or handing its byte over;
   // a full FIFO still accepts a write on a cycle it is being read
   assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
   assign fifo_rd   = (fifo_level != '0) && (!tx_data_valid || tx_data_ready);
   assign fifo_wr   = sel_valid && (!fifo_full || fifo_rd);

   // FIFO storage; contents need no reset because the level gates reads
   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= evt_byte;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (sel_valid && !fifo_wr) overflow <= 1'b1;
      end
   end

   // Registered output stage; tx_data holds while valid waits for ready
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data       <= 8'h00;
         tx_data_valid <= 1'b0;
      end else if (fifo_rd) begin
         tx_data       <= mem[rd_ptr];
         tx_data_valid <= 1'b1;
      end else if (tx_data_ready) begin
         tx_data_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_button_event_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_button_event_tx
// Purpose  : Directed self-checking bench for button_event_tx (4 buttons,
//            active-low, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_event_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'hF;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready = 1'b1;
   logic [2:0] fifo_level;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n0;

   logic [7:0] got_b [$];
   int         got_c [$];

   button_event_tx #(
      .NUM_BTN(4),
      .DEBOUNCE_CYCLES(16),
      .FIFO_DEPTH(4),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .tx_data(tx_data),
      .tx_data_valid(tx_data_valid),
      .tx_data_ready(tx_data_ready),
      .fifo_level(fifo_level),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Record every transferred byte and the cycle it was accepted on
   always @(posedge clk) begin
      if (!rst && tx_data_valid && tx_data_ready) begin
         got_b.push_back(tx_data);
         got_c.push_back(cyc);
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] byte_at(input int k);
      return (k < got_b.size()) ? {24'd0, got_b[k]} : 32'hDEAD;
   endfunction

   function automatic int stamp_at(input int k);
      return (k < got_c.size()) ? got_c[k] : -1000;
   endfunction

   // Directed sequence
   initial begin
      // Reset state
      tick(3);
      check("rst_data",  tx_data, 8'h00);
      check("rst_valid", tx_data_valid, 1'b0);
      check("rst_level", fifo_level, 3'd0);
      check("rst_ovf",   overflow, 1'b0);
      rst = 1'b0;
      tick(5);

      // Clean press / release of btn[2]
      n0 = got_b.size();
      btn = 4'b1011;
`ifndef BUTTON_EVT_DEBOUNCE_EN
      tick(4);
      check("lat_level_w", fifo_level, 3'd1);
      check("lat_valid_w", tx_data_valid, 1'b0);
      tick(1);
      check("lat_valid",   tx_data_valid, 1'b1);
      check("lat_data",    tx_data, 8'h43);
      check("lat_level_r", fifo_level, 3'd0);
`endif
      tick(40);
      check("press2_cnt",  got_b.size() - n0, 1);
      check("press2_byte", byte_at(n0), 8'h43);
      btn = 4'hF;
      tick(40);
      check("rel2_cnt",  got_b.size() - n0, 2);
      check("rel2_byte", byte_at(n0 + 1), 8'h63);

      // Simultaneous press of buttons 0, 1 and 3, delivered back to back
      n0 = got_b.size();
      btn = 4'b0100;
      tick(40);
      check("multi_cnt", got_b.size() - n0, 3);
      check("multi_b0",  byte_at(n0),     8'h41);
      check("multi_b1",  byte_at(n0 + 1), 8'h42);
      check("multi_b2",  byte_at(n0 + 2), 8'h44);
      check("multi_gap1", stamp_at(n0 + 1) - stamp_at(n0), 1);
      check("multi_gap2", stamp_at(n0 + 2) - stamp_at(n0 + 1), 1);
      btn = 4'hF;
      tick(40);
      check("multi_rel_cnt", got_b.size() - n0, 6);
      check("multi_rel_b0",  byte_at(n0 + 3), 8'h61);
      check("multi_rel_b2",  byte_at(n0 + 5), 8'h64);

      // Overflow: six events with the transmitter stalled
      n0 = got_b.size();
      tx_data_ready = 1'b0;
      btn = 4'b1000;
      tick(40);
      btn = 4'hF;
      tick(40);
      check("ovf_level", fifo_level, 3'd4);
      check("ovf_flag",  overflow, 1'b1);
      check("ovf_valid", tx_data_valid, 1'b1);
      check("ovf_head",  tx_data, 8'h41);
      check("ovf_nodrain", got_b.size() - n0, 0);
      tx_data_ready = 1'b1;
      tick(20);
      check("drain_cnt", got_b.size() - n0, 5);
      check("drain_b0",  byte_at(n0),     8'h41);
      check("drain_b1",  byte_at(n0 + 1), 8'h42);
      check("drain_b2",  byte_at(n0 + 2), 8'h43);
      check("drain_b3",  byte_at(n0 + 3), 8'h61);
      check("drain_b4",  byte_at(n0 + 4), 8'h62);
      check("drain_level", fifo_level, 3'd0);
      check("drain_valid", tx_data_valid, 1'b0);
      check("ovf_sticky",  overflow, 1'b1);

      // Reset with three queued bytes discards everything
      tx_data_ready = 1'b0;
      btn = 4'b0000;
      tick(40);
      check("pre_rst_level", fifo_level, 3'd3);
      rst = 1'b1;
      btn = 4'hF;
      tick(1);
      rst = 1'b0;
      check("mid_rst_valid", tx_data_valid, 1'b0);
      check("mid_rst_level", fifo_level, 3'd0);
      check("mid_rst_ovf",   overflow, 1'b0);
      check("mid_rst_data",  tx_data, 8'h00);
      n0 = got_b.size();
      tx_data_ready = 1'b1;
      tick(40);
      check("post_rst_quiet", got_b.size() - n0, 0);

      // Button held through reset yields a press afterwards
      rst = 1'b1;
      btn = 4'b0111;
      tick(3);
      rst = 1'b0;
      n0 = got_b.size();
      tick(40);
      check("held_cnt",  got_b.size() - n0, 1);
      check("held_byte", byte_at(n0), 8'h44);
      btn = 4'hF;
      tick(40);
      check("held_rel", byte_at(n0 + 1), 8'h64);

`ifdef BUTTON_EVT_DEBOUNCE_EN
      // Bouncing btn[0] with 5-cycle pulses, then held
      n0 = got_b.size();
      for (int k = 0; k < 20; k++) begin
         btn = (k % 2 == 0) ? 4'b1110 : 4'hF;
         tick(5);
      end
      check("bounce_quiet", got_b.size() - n0, 0);
      btn = 4'b1110;
      tick(40);
      check("bounce_cnt",  got_b.size() - n0, 1);
      check("bounce_byte", byte_at(n0), 8'h41);
      btn = 4'hF;
      tick(40);
      check("bounce_rel", byte_at(n0 + 1), 8'h61);
`else
      // One-cycle glitch on btn[1] is passed through as press + release
      n0 = got_b.size();
      btn = 4'b1101;
      tick(1);
      btn = 4'hF;
      tick(20);
      check("glitch_cnt", got_b.size() - n0, 2);
      check("glitch_b0",  byte_at(n0),     8'h42);
      check("glitch_b1",  byte_at(n0 + 1), 8'h62);
`endif

      check("end_level", fifo_level, 3'd0);
      check("end_ovf",   overflow, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
